mem_io_router: RTL and testbench

- Parametrised byte-wide bus router that replaces the hand-wired RAM/IO muxing at the top level.
- Arbitrates NUM_MASTERS requesters (master 0 = host/debug interface with fixed top priority; the rest are CPU-side ports served round-robin) onto one synchronous single-port RAM and one IO port.
- Decodes the IO window, stalls IO writes while the IO buffer is full, and steers read data back to the owning master one cycle later through a registered source/owner record.

---
 rtl/mem_io_router_pkg.sv | 20 ++
 rtl/mem_io_router_rr_arbiter.sv | 68 ++++++
 rtl/mem_io_router.sv | 136 +++++++++++++
 tb/tb_mem_io_router.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_router_pkg.sv
// Shared definitions for the RAM/IO bus router and the host-side interface.
package mem_io_router_pkg;

    // Default memory map: 128 KiB of RAM; tag 2'b11 in the two bits at the
    // top of the RAM window selects IO space.
    localparam int         RAM_ADDR_WIDTH_DEF = 17;
    localparam int         IO_SEL_WIDTH_DEF   = 3;
    localparam logic [1:0] IO_TAG_DEF         = 2'b11;

    // IO register select codes shared with the host interface.
    localparam logic [2:0] IO_SEL_UART_DATA   = 3'd0;
    localparam logic [2:0] IO_SEL_FINISH      = 3'd7;

    // True when the two tag bits of an address fall in the IO window.
    function automatic logic in_io_window(input logic [1:0] tag_bits,
                                          input logic [1:0] io_tag);
        return (tag_bits == io_tag);
    endfunction

endpackage

// File: rtl/mem_io_router_rr_arbiter.sv
// N-way arbiter: index 0 always wins when eligible; indices 1..N-1 are
// served round-robin starting at rr_ptr.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  elig,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] win,
    output logic          any
);

    // Modulus for the cyclic scan over 1..N-1; kept non-zero for N == 1.
    localparam int NR = (N > 1) ? (N - 1) : 1;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_next;
    int            cand;

    // Pick the winner: fixed priority for index 0, else first eligible at or after rr_ptr.
    always_comb begin
        gnt  = '0;
        win  = '0;
        any  = 1'b0;
        cand = 0;
        if (elig[0]) begin
            gnt[0] = 1'b1;
            any    = 1'b1;
        end else begin
            for (int off = 0; off < N - 1; off++) begin
                cand = ((int'(rr_ptr) - 1 + off) % NR) + 1;
                if (!any && elig[cand]) begin
                    gnt[cand] = 1'b1;
                    win       = IW'(cand);
                    any       = 1'b1;
                end else begin
                    any = any;
                end
            end
        end
    end

    // Advance the pointer past a round-robin winner; grants to index 0 leave it alone.
    always_comb begin
        rr_next = rr_ptr;
        if (any && (win != '0)) begin
            if (int'(win) == N - 1) begin
                rr_next = IW'(1);
            end else begin
                rr_next = win + IW'(1);
            end
        end else begin
            rr_next = rr_ptr;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= IW'((N > 1) ? 1 : 0);
        end else begin
            rr_ptr <= rr_next;
        end
    end

endmodule

// File: rtl/mem_io_router.sv
// Byte-wide router: arbitrates masters onto one synchronous RAM and one IO
// port, and steers read data back to the owner one cycle after the grant.
module mem_io_router
    import mem_io_router_pkg::*;
#(
    parameter int         NUM_MASTERS    = 2,
    parameter int         ADDR_WIDTH     = 32,
    parameter int         RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
    parameter int         IO_SEL_WIDTH   = IO_SEL_WIDTH_DEF,
    parameter logic [1:0] IO_TAG         = IO_TAG_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS-1:0]          m_req,
    input  logic [NUM_MASTERS-1:0]          m_wr,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*8-1:0]        m_wdata,
    output logic [NUM_MASTERS-1:0]          m_gnt,
    output logic [NUM_MASTERS-1:0]          m_rvalid,
    output logic [7:0]                      m_rdata,
    output logic                            ram_we,
    output logic [RAM_ADDR_WIDTH-1:0]       ram_addr,
    output logic [7:0]                      ram_din,
    input  logic [7:0]                      ram_dout,
    output logic                            io_en,
    output logic [IO_SEL_WIDTH-1:0]         io_sel,
    output logic                            io_wr,
    output logic [7:0]                      io_din,
    input  logic [7:0]                      io_dout,
    input  logic                            io_full
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0]    elig;
    logic [IW-1:0]             win;
    logic                      any;
    logic [ADDR_WIDTH-1:0]     win_addr;
    logic [7:0]                win_wdata;
    logic                      win_wr;
    logic                      win_io;
    logic [RAM_ADDR_WIDTH-1:0] last_addr;
    logic                      rd_pend;
    logic                      rd_src_io;
    logic [IW-1:0]             rd_owner;
    logic                      unused_addr_bits;

    // Mask IO writes while the IO buffer is full; nothing is eligible during reset.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            elig[i] = m_req[i] & ~rst &
                      ~(in_io_window(m_addr[i*ADDR_WIDTH+RAM_ADDR_WIDTH -: 2], IO_TAG) &
                        m_wr[i] & io_full);
        end
    end

    rr_arbiter #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .elig (elig),
        .gnt  (m_gnt),
        .win  (win),
        .any  (any)
    );

    // Select the winning master's request fields.
    always_comb begin
        win_addr  = m_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = m_wdata[int'(win)*8 +: 8];
        win_wr    = m_wr[win];
        win_io    = in_io_window(win_addr[RAM_ADDR_WIDTH -: 2], IO_TAG);
    end

    // Upper address bits alias and are deliberately ignored.
    assign unused_addr_bits = ^win_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+1];

    // Drive the RAM or IO port from the winner; idle cycles keep the last RAM address.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = last_addr;
        ram_din  = 8'h00;
        io_en    = 1'b0;
        io_wr    = 1'b0;
        io_sel   = '0;
        io_din   = 8'h00;
        if (any) begin
            ram_addr = win_addr[RAM_ADDR_WIDTH-1:0];
            ram_din  = win_wdata;
            if (win_io) begin
                io_en  = 1'b1;
                io_wr  = win_wr;
                io_sel = win_addr[IO_SEL_WIDTH-1:0];
                io_din = win_wdata;
            end else begin
                ram_we = win_wr;
            end
        end else begin
            ram_addr = last_addr;
        end
    end

    // Remember the last granted address and record the owner/source of a granted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr <= '0;
            rd_pend   <= 1'b0;
            rd_src_io <= 1'b0;
            rd_owner  <= '0;
        end else begin
            if (any) begin
                last_addr <= win_addr[RAM_ADDR_WIDTH-1:0];
            end else begin
                last_addr <= last_addr;
            end
            rd_pend   <= any & ~win_wr;
            rd_src_io <= any & win_io;
            rd_owner  <= win;
        end
    end

    // Return read data to the owner of last cycle's read.
    always_comb begin
        m_rvalid = '0;
        if (rd_pend) begin
            m_rvalid[rd_owner] = 1'b1;
        end else begin
            m_rvalid = '0;
        end
        m_rdata = (rd_pend && rd_src_io) ? io_dout : ram_dout;
    end

endmodule

// File: tb/tb_mem_io_router.sv
// Directed bench for mem_io_router with three masters (M0 host, M1/M2 round-robin).
module tb_mem_io_router;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int RW = 17;
    localparam int SW = 3;

    logic          clk;
    logic          rst;
    logic [N-1:0]  m_req;
    logic [N-1:0]  m_wr;
    logic [N*AW-1:0] m_addr;
    logic [N*8-1:0]  m_wdata;
    logic [N-1:0]  m_gnt;
    logic [N-1:0]  m_rvalid;
    logic [7:0]    m_rdata;
    logic          ram_we;
    logic [RW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;
    logic          io_en;
    logic [SW-1:0] io_sel;
    logic          io_wr;
    logic [7:0]    io_din;
    logic [7:0]    io_dout;
    logic          io_full;

    int n_cmp;
    int n_bad;

    mem_io_router #(
        .NUM_MASTERS    (N),
        .ADDR_WIDTH     (AW),
        .RAM_ADDR_WIDTH (RW),
        .IO_SEL_WIDTH   (SW),
        .IO_TAG         (2'b11)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .io_en    (io_en),
        .io_sel   (io_sel),
        .io_wr    (io_wr),
        .io_din   (io_din),
        .io_dout  (io_dout),
        .io_full  (io_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic req, input logic wr,
                         input logic [31:0] addr, input logic [7:0] wd);
        m_req[i]            = req;
        m_wr[i]             = wr;
        m_addr[i*AW +: AW]  = addr;
        m_wdata[i*8 +: 8]   = wd;
    endtask

    task automatic clr_all();
        for (int i = 0; i < N; i++) set_m(i, 1'b0, 1'b0, 32'h0, 8'h00);
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        m_req    = '0;
        m_wr     = '0;
        m_addr   = '0;
        m_wdata  = '0;
        ram_dout = 8'h00;
        io_dout  = 8'h00;
        io_full  = 1'b0;

        // Reset: outputs idle even with a request present.
        set_m(1, 1'b1, 1'b0, 32'h0000_0100, 8'h00);
        #2;
        chk("rst_gnt",    32'(m_gnt),    32'h0);
        chk("rst_rvalid", 32'(m_rvalid), 32'h0);
        chk("rst_ram_we", 32'(ram_we),   32'h0);
        chk("rst_io_en",  32'(io_en),    32'h0);
        chk("rst_io_wr",  32'(io_wr),    32'h0);
        clr_all();
        tick();
        tick();
        rst = 1'b0;

        // Round-robin M1/M2 reads from reset pointer: 1,2,1,2,1 with pipelined returns.
        set_m(1, 1'b1, 1'b0, 32'h0000_0010, 8'h00);
        set_m(2, 1'b1, 1'b0, 32'h0000_0020, 8'h00);
        ram_dout = 8'h11;
        #1;
        chk("rr_gnt0", 32'(m_gnt),    32'h2);
        chk("rr_addr0", 32'(ram_addr), 32'h10);
        chk("rr_rv0",  32'(m_rvalid), 32'h0);
        tick(); #1;
        chk("rr_gnt1", 32'(m_gnt),    32'h4);
        chk("rr_addr1", 32'(ram_addr), 32'h20);
        chk("rr_rv1",  32'(m_rvalid), 32'h2);
        chk("rr_dat1", 32'(m_rdata),  32'h11);
        tick(); #1;
        chk("rr_gnt2", 32'(m_gnt),    32'h2);
        chk("rr_rv2",  32'(m_rvalid), 32'h4);
        tick(); #1;
        chk("rr_gnt3", 32'(m_gnt),    32'h4);
        chk("rr_rv3",  32'(m_rvalid), 32'h2);
        tick(); #1;
        chk("rr_wrap", 32'(m_gnt),    32'h2);
        chk("rr_rv4",  32'(m_rvalid), 32'h4);
        tick();
        clr_all();
        #1;
        chk("idle_gnt",  32'(m_gnt),    32'h0);
        chk("idle_rv",   32'(m_rvalid), 32'h2);
        chk("idle_hold", 32'(ram_addr), 32'h10);
        chk("idle_we",   32'(ram_we),   32'h0);

        // M1 reads RAM 0x00100 holding 0xA5.
        tick();
        set_m(1, 1'b1, 1'b0, 32'h0000_0100, 8'h00);
        #1;
        chk("rd_gnt",  32'(m_gnt),    32'h2);
        chk("rd_addr", 32'(ram_addr), 32'h100);
        chk("rd_we",   32'(ram_we),   32'h0);
        chk("rd_io",   32'(io_en),    32'h0);
        tick();
        clr_all();
        ram_dout = 8'hA5;
        #1;
        chk("rd_rv",   32'(m_rvalid), 32'h2);
        chk("rd_dat",  32'(m_rdata),  32'hA5);
        tick(); #1;
        chk("rd_rv_off", 32'(m_rvalid), 32'h0);

        // M0 fixed priority starves M1 for 4 cycles; M0 writes RAM.
        set_m(0, 1'b1, 1'b1, 32'h0000_0200, 8'h77);
        set_m(1, 1'b1, 1'b0, 32'h0000_0300, 8'h00);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("pri_gnt", 32'(m_gnt),   32'h1);
            chk("pri_we",  32'(ram_we),  32'h1);
            chk("pri_din", 32'(ram_din), 32'h77);
            chk("pri_rv",  32'(m_rvalid), 32'h0);
            tick();
        end
        set_m(0, 1'b0, 1'b0, 32'h0, 8'h00);
        #1;
        chk("unstarve_gnt",  32'(m_gnt),    32'h2);
        chk("unstarve_addr", 32'(ram_addr), 32'h300);
        chk("unstarve_we",   32'(ram_we),   32'h0);
        tick();
        clr_all();
        ram_dout = 8'h5C;
        #1;
        chk("unstarve_rv",  32'(m_rvalid), 32'h2);
        chk("unstarve_dat", 32'(m_rdata),  32'h5C);

        // IO write stalled by io_full for 3 cycles, then accepted.
        tick();
        set_m(1, 1'b1, 1'b1, 32'h0003_0000, 8'h41);
        io_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("full_gnt", 32'(m_gnt),  32'h0);
            chk("full_io",  32'(io_en),  32'h0);
            chk("full_we",  32'(ram_we), 32'h0);
            tick();
        end
        io_full = 1'b0;
        #1;
        chk("iow_gnt", 32'(m_gnt),  32'h2);
        chk("iow_en",  32'(io_en),  32'h1);
        chk("iow_wr",  32'(io_wr),  32'h1);
        chk("iow_sel", 32'(io_sel), 32'h0);
        chk("iow_din", 32'(io_din), 32'h41);
        chk("iow_we",  32'(ram_we), 32'h0);

        // Full IO write masked in the same cycle; lower master M2 wins instead.
        tick();
        io_full = 1'b1;
        set_m(2, 1'b1, 1'b0, 32'h0000_0040, 8'h00);
        #1;
        chk("iow_rv",    32'(m_rvalid), 32'h0);
        chk("mask_gnt",  32'(m_gnt),    32'h4);
        chk("mask_io",   32'(io_en),    32'h0);
        tick();
        clr_all();
        io_full  = 1'b0;
        ram_dout = 8'h66;
        #1;
        chk("mask_rv",  32'(m_rvalid), 32'h4);
        chk("mask_dat", 32'(m_rdata),  32'h66);

        // IO read then RAM read: data returns from IO, then RAM, back to back.
        tick();
        set_m(1, 1'b1, 1'b0, 32'h0003_0004, 8'h00);
        #1;
        chk("ior_gnt", 32'(m_gnt),  32'h2);
        chk("ior_en",  32'(io_en),  32'h1);
        chk("ior_wr",  32'(io_wr),  32'h0);
        chk("ior_sel", 32'(io_sel), 32'h4);
        tick();
        set_m(1, 1'b1, 1'b0, 32'h0000_0200, 8'h00);
        io_dout  = 8'h5A;
        ram_dout = 8'h99;
        #1;
        chk("ior2_gnt", 32'(m_gnt),    32'h2);
        chk("ior2_io",  32'(io_en),    32'h0);
        chk("ior_rv",   32'(m_rvalid), 32'h2);
        chk("ior_dat",  32'(m_rdata),  32'h5A);
        tick();
        clr_all();
        io_dout  = 8'h77;
        ram_dout = 8'h3C;
        #1;
        chk("ramr_rv",  32'(m_rvalid), 32'h2);
        chk("ramr_dat", 32'(m_rdata),  32'h3C);

        // Upper address bits alias: RAM and IO decode use only the low bits.
        tick();
        set_m(2, 1'b1, 1'b0, 32'hFFFC_0123, 8'h00);
        #1;
        chk("alias_gnt",  32'(m_gnt),    32'h4);
        chk("alias_addr", 32'(ram_addr), 32'h00123);
        chk("alias_io",   32'(io_en),    32'h0);
        tick();
        clr_all();
        set_m(1, 1'b1, 1'b0, 32'h00F3_0005, 8'h00);
        #1;
        chk("alias_io_en",  32'(io_en),  32'h1);
        chk("alias_io_sel", 32'(io_sel), 32'h5);

        // Reset in the cycle after a granted read drops its return.
        tick();
        set_m(1, 1'b1, 1'b0, 32'h0000_0100, 8'h00);
        #1;
        chk("rr_gnt", 32'(m_gnt), 32'h2);
        tick();
        rst = 1'b1;
        clr_all();
        #1;
        chk("mrst_rv",  32'(m_rvalid), 32'h0);
        chk("mrst_gnt", 32'(m_gnt),    32'h0);
        chk("mrst_we",  32'(ram_we),   32'h0);
        chk("mrst_io",  32'(io_en),    32'h0);
        chk("mrst_iow", 32'(io_wr),    32'h0);
        tick(); #1;
        chk("mrst_rv2", 32'(m_rvalid), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rv", 32'(m_rvalid), 32'h0);
        tick(); #1;
        chk("post_rv2", 32'(m_rvalid), 32'h0);

        // Pointer is back at 1 after reset: M1 beats M2.
        set_m(1, 1'b1, 1'b0, 32'h0000_0010, 8'h00);
        set_m(2, 1'b1, 1'b0, 32'h0000_0020, 8'h00);
        #1;
        chk("post_ptr", 32'(m_gnt), 32'h2);
        tick();
        clr_all();
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
